// File: rtl/decode_pkg.sv
// Shared RV64I decode definitions: base opcodes, immediate formats and the
// immediate assembly helper used by the decode stage.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // 32-bit signed immediate; callers sign-extend to the datapath width.
  function automatic logic signed [31:0] imm32(input logic [31:0] instr,
                                               input imm_fmt_e    fmt);
    logic signed [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'h000};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of fetch, register-file read, downstream and writeback signals seen
// by the decode stage. slave is the stage's view, master the environment's.
interface decode_stage_if #(
  parameter int XLEN = 64
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            flush;
  logic            rf_read;
  logic [4:0]      rf_rs1;
  logic [4:0]      rf_rs2;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [4:0]      id_rd;
  logic            id_we;
  logic [XLEN-1:0] id_imm;
  logic            id_illegal;
  logic            wb_valid;
  logic [4:0]      wb_rd;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, id_ready, wb_valid, wb_rd,
    output if_ready, rf_read, rf_rs1, rf_rs2,
    output id_valid, id_pc, id_opcode, id_funct3, id_funct7, id_rd, id_we,
    output id_imm, id_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, id_ready, wb_valid, wb_rd,
    input  if_ready, rf_read, rf_rs1, rf_rs2,
    input  id_valid, id_pc, id_opcode, id_funct3, id_funct7, id_rd, id_we,
    input  id_imm, id_illegal
  );
endinterface

// File: rtl/decode_stage_scoreboard.sv
// Per-register busy bits for in-flight producers; a set and clear of the same
// index in one cycle leaves the bit set.
module decode_stage_scoreboard #(
  parameter  int NREGS = 32,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic [IW-1:0] look_a,
  input  logic [IW-1:0] look_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~clr_mask) | set_mask;
  end

  assign busy_a = busy[look_a];
  assign busy_b = busy[look_b];

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: decodes one instruction per cycle, drives the register
// file read port and stalls read-after-write hazards via a busy scoreboard.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic           clock,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  logic [6:0]      opc_p0;
  logic [4:0]      rd_p0, rs1_p0, rs2_p0;
  imm_fmt_e        fmt_p0;
  logic            use_rs1_p0, use_rs2_p0, legal_p0, no_rd_p0, we_p0;
  logic [XLEN-1:0] imm_p0;
  logic signed [31:0] imm32_p0;
  logic            busy1_p0, busy2_p0, hz1_p0, hz2_p0, hazard_p0;
  logic            ready_p0, accept_p0, sb_set, sb_clr;

  logic            vld_p1;
  logic [XLEN-1:0] pc_p1, imm_p1;
  logic [6:0]      opc_p1, funct7_p1;
  logic [2:0]      funct3_p1;
  logic [4:0]      rd_p1;
  logic            we_p1, illegal_p1;

  assign opc_p0 = bus.if_instr[6:0];
  assign rd_p0  = bus.if_instr[11:7];
  assign rs1_p0 = bus.if_instr[19:15];
  assign rs2_p0 = bus.if_instr[24:20];

  always_comb begin
    fmt_p0     = FMT_I;
    use_rs1_p0 = 1'b1;
    use_rs2_p0 = 1'b0;
    legal_p0   = 1'b1;
    no_rd_p0   = 1'b0;
    case (opc_p0)
      OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: fmt_p0 = FMT_I;
      OPC_SYSTEM: begin fmt_p0 = FMT_I; no_rd_p0 = 1'b1; end
      OPC_STORE:  begin fmt_p0 = FMT_S; use_rs2_p0 = 1'b1; no_rd_p0 = 1'b1; end
      OPC_BRANCH: begin fmt_p0 = FMT_B; use_rs2_p0 = 1'b1; no_rd_p0 = 1'b1; end
      OPC_OP, OPC_OP32: begin fmt_p0 = FMT_R; use_rs2_p0 = 1'b1; end
      OPC_LUI, OPC_AUIPC: begin fmt_p0 = FMT_U; use_rs1_p0 = 1'b0; end
      OPC_JAL:    begin fmt_p0 = FMT_J; use_rs1_p0 = 1'b0; end
      // Unknown opcodes read nothing so they never stall on garbage fields.
      default: begin
        fmt_p0     = FMT_R;
        use_rs1_p0 = 1'b0;
        legal_p0   = 1'b0;
        no_rd_p0   = 1'b1;
      end
    endcase
  end

  assign we_p0    = legal_p0 & ~no_rd_p0 & (rd_p0 != 5'd0);
  assign imm32_p0 = imm32(bus.if_instr, fmt_p0);
  assign imm_p0   = {{(XLEN-32){imm32_p0[31]}}, imm32_p0};

  decode_stage_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .set_en  (sb_set),
    .set_idx (rd_p1),
    .clr_en  (sb_clr),
    .clr_idx (bus.wb_rd),
    .look_a  (rs1_p0),
    .look_b  (rs2_p0),
    .busy_a  (busy1_p0),
    .busy_b  (busy2_p0)
  );

  // The instruction still in the stage is not yet in the scoreboard, so its rd
  // is compared directly; a same-cycle wb leaves the busy bit visible here.
  assign hz1_p0 = use_rs1_p0 & (rs1_p0 != 5'd0) &
                  (busy1_p0 | (vld_p1 & we_p1 & (rd_p1 == rs1_p0)));
  assign hz2_p0 = use_rs2_p0 & (rs2_p0 != 5'd0) &
                  (busy2_p0 | (vld_p1 & we_p1 & (rd_p1 == rs2_p0)));
  assign hazard_p0 = hz1_p0 | hz2_p0;

  assign ready_p0  = ~reset & ~bus.flush & ~hazard_p0 & (~vld_p1 | bus.id_ready);
  assign accept_p0 = bus.if_valid & ready_p0;
  assign sb_set    = vld_p1 & bus.id_ready & we_p1 & ~bus.flush;
  assign sb_clr    = bus.wb_valid & (bus.wb_rd != 5'd0);

  assign bus.if_ready = ready_p0;
  assign bus.rf_read  = accept_p0;
  assign bus.rf_rs1   = rs1_p0;
  assign bus.rf_rs2   = rs2_p0;

  // p0 -> p1: decoded fields land alongside the register file read data
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      imm_p1     <= '0;
      opc_p1     <= '0;
      funct3_p1  <= '0;
      funct7_p1  <= '0;
      rd_p1      <= '0;
      we_p1      <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1     <= 1'b1;
      pc_p1      <= bus.if_pc;
      imm_p1     <= imm_p0;
      opc_p1     <= opc_p0;
      funct3_p1  <= bus.if_instr[14:12];
      funct7_p1  <= bus.if_instr[31:25];
      rd_p1      <= rd_p0;
      we_p1      <= we_p0;
      illegal_p1 <= ~legal_p0;
    end else if (bus.id_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.id_valid   = vld_p1;
  assign bus.id_pc      = pc_p1;
  assign bus.id_opcode  = opc_p1;
  assign bus.id_funct3  = funct3_p1;
  assign bus.id_funct7  = funct7_p1;
  assign bus.id_rd      = rd_p1;
  assign bus.id_we      = we_p1;
  assign bus.id_imm     = imm_p1;
  assign bus.id_illegal = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, RAW stalls, backpressure,
// flush and reset-while-stalled, with hand-computed expectations.
module tb_decode_stage;

  localparam logic [31:0] ADDI_X5   = 32'h00700293;
  localparam logic [31:0] ADD_X6_X5 = 32'h00528333;
  localparam logic [31:0] BEQ_M4    = 32'hFE000EE3;
  localparam logic [31:0] LUI_X1    = 32'h123450B7;
  localparam logic [31:0] ADDI_X7   = 32'h00100393;
  localparam logic [31:0] ADD_X8_X7 = 32'h00038433;
  localparam logic [31:0] BAD_OPC   = 32'h000000FF;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;

  decode_stage_if #(.XLEN(64)) bus ();

  decode_stage #(.XLEN(64), .NREGS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr,
                       input logic [63:0] pc, input logic rdy);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
    bus.id_ready = rdy;
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.flush    = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = 5'd0;
    drive(1'b1, ADDI_X5, 64'h1000, 1'b1);
    chk_eq("rst_if_ready", 64'(bus.if_ready), 64'd0);
    chk_eq("rst_rf_read", 64'(bus.rf_read), 64'd0);
    tick();
    tick();
    chk_eq("rst_id_valid", 64'(bus.id_valid), 64'd0);
    chk_eq("rst_id_imm", bus.id_imm, 64'd0);
    chk_eq("rst_id_rd", 64'(bus.id_rd), 64'd0);

    // addi x5,x0,7
    reset = 1'b0;
    drive(1'b1, ADDI_X5, 64'h1000, 1'b1);
    chk_eq("addi_rf_read", 64'(bus.rf_read), 64'd1);
    chk_eq("addi_rf_rs1", 64'(bus.rf_rs1), 64'd0);
    tick();
    chk_eq("addi_id_valid", 64'(bus.id_valid), 64'd1);
    chk_eq("addi_id_rd", 64'(bus.id_rd), 64'd5);
    chk_eq("addi_id_we", 64'(bus.id_we), 64'd1);
    chk_eq("addi_id_imm", bus.id_imm, 64'd7);
    chk_eq("addi_id_opcode", 64'(bus.id_opcode), 64'h13);
    chk_eq("addi_id_pc", bus.id_pc, 64'h1000);

    // add x6,x5,x5 stalls on the in-stage producer, then on busy[5]
    drive(1'b1, ADD_X6_X5, 64'h1004, 1'b1);
    chk_eq("raw_stage_stall", 64'(bus.if_ready), 64'd0);
    tick();
    drive(1'b1, ADD_X6_X5, 64'h1004, 1'b1);
    chk_eq("raw_busy_stall", 64'(bus.if_ready), 64'd0);
    chk_eq("raw_busy_rf_read", 64'(bus.rf_read), 64'd0);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    drive(1'b1, ADD_X6_X5, 64'h1004, 1'b1);
    chk_eq("raw_wb_cycle_stall", 64'(bus.if_ready), 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    drive(1'b1, ADD_X6_X5, 64'h1004, 1'b1);
    chk_eq("raw_release", 64'(bus.if_ready), 64'd1);
    chk_eq("raw_rf_rs2", 64'(bus.rf_rs2), 64'd5);
    tick();
    chk_eq("add_id_rd", 64'(bus.id_rd), 64'd6);
    chk_eq("add_id_imm", bus.id_imm, 64'd0);

    // beq x0,x0,-4 (add x6 handshakes -> busy[6])
    drive(1'b1, BEQ_M4, 64'h1008, 1'b1);
    chk_eq("beq_accept", 64'(bus.if_ready), 64'd1);
    tick();
    chk_eq("beq_id_imm", bus.id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk_eq("beq_id_we", 64'(bus.id_we), 64'd0);
    chk_eq("beq_id_opcode", 64'(bus.id_opcode), 64'h63);

    // lui x1,0x12345 while retiring x6
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd6;
    drive(1'b1, LUI_X1, 64'h100C, 1'b1);
    tick();
    bus.wb_valid = 1'b0;
    chk_eq("lui_id_imm", bus.id_imm, 64'h0000_0000_1234_5000);
    chk_eq("lui_id_rd", 64'(bus.id_rd), 64'd1);

    // backpressure: three cycles of id_ready=0
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDI_X7, 64'h1010, 1'b0);
      chk_eq("bp_if_ready", 64'(bus.if_ready), 64'd0);
      chk_eq("bp_rf_read", 64'(bus.rf_read), 64'd0);
      tick();
      chk_eq("bp_id_valid", 64'(bus.id_valid), 64'd1);
      chk_eq("bp_id_imm", bus.id_imm, 64'h0000_0000_1234_5000);
    end
    drive(1'b0, ADDI_X7, 64'h1010, 1'b1);
    tick();
    chk_eq("bp_drain", 64'(bus.id_valid), 64'd0);
    // addi x9,x1,0 must now see busy[1]
    drive(1'b1, 32'h00008493, 64'h1014, 1'b1);
    chk_eq("bp_busy_set", 64'(bus.if_ready), 64'd0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    drive(1'b0, 32'h00008493, 64'h1014, 1'b1);
    tick();
    bus.wb_valid = 1'b0;

    // flush the held addi x7
    drive(1'b1, ADDI_X7, 64'h1018, 1'b1);
    tick();
    chk_eq("fl_id_rd", 64'(bus.id_rd), 64'd7);
    bus.flush = 1'b1;
    drive(1'b1, ADD_X8_X7, 64'h101C, 1'b1);
    chk_eq("fl_if_ready", 64'(bus.if_ready), 64'd0);
    chk_eq("fl_rf_read", 64'(bus.rf_read), 64'd0);
    tick();
    bus.flush = 1'b0;
    chk_eq("fl_id_valid", 64'(bus.id_valid), 64'd0);
    drive(1'b1, ADD_X8_X7, 64'h101C, 1'b1);
    chk_eq("fl_no_stall", 64'(bus.if_ready), 64'd1);
    tick();
    chk_eq("fl_add_rd", 64'(bus.id_rd), 64'd8);

    // reset while stalled on busy x5
    drive(1'b1, ADDI_X5, 64'h1020, 1'b1);
    tick();
    drive(1'b1, ADD_X6_X5, 64'h1024, 1'b1);
    tick();
    drive(1'b1, ADD_X6_X5, 64'h1024, 1'b1);
    chk_eq("rs_stalled", 64'(bus.if_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_eq("rs_id_valid", 64'(bus.id_valid), 64'd0);
    drive(1'b1, ADD_X6_X5, 64'h1024, 1'b1);
    chk_eq("rs_no_stall", 64'(bus.if_ready), 64'd1);
    tick();
    chk_eq("rs_add_valid", 64'(bus.id_valid), 64'd1);

    // unknown opcode still flows with id_we=0
    drive(1'b1, BAD_OPC, 64'h1028, 1'b1);
    tick();
    chk_eq("ill_id_illegal", 64'(bus.id_illegal), 64'd1);
    chk_eq("ill_id_we", 64'(bus.id_we), 64'd0);
    chk_eq("ill_id_valid", 64'(bus.id_valid), 64'd1);

    drive(1'b0, 32'h0, 64'h0, 1'b1);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
